// File: rtl/rns_pkg.sv
// Shared constants and helpers for the three-modulus RNS datapath.
// Moduli defaults, derived range/width, and CRT weight computation.
package rns_pkg;

    localparam int RNS_M1 = 7;
    localparam int RNS_M2 = 8;
    localparam int RNS_M3 = 9;
    localparam int RNS_M  = RNS_M1 * RNS_M2 * RNS_M3;
    localparam int RNS_WM = $clog2(RNS_M);

    // Weight = (m/mi) * inverse of (m/mi) modulo mi, inverse found by search.
    function automatic int crt_weight(input int mi, input int m);
        int q;
        int w;
        q = m / mi;
        w = 0;
        for (int k = 1; k < mi; k++) begin
            if (w == 0 && ((q * k) % mi) == 1) begin
                w = q * k;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rns_crt_to_bin.sv
// Residue-to-binary conversion: range check and weighted terms,
// then summation with mod-M reduction. Two stages, shared enable.
module rns_crt_to_bin
    import rns_pkg::*;
#(
    parameter int M1 = RNS_M1,
    parameter int M2 = RNS_M2,
    parameter int M3 = RNS_M3,
    localparam int W1 = $clog2(M1),
    localparam int W2 = $clog2(M2),
    localparam int W3 = $clog2(M3),
    localparam int M  = M1 * M2 * M3,
    localparam int WM = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_valid,
    input  logic [W1-1:0] i_x1,
    input  logic [W2-1:0] i_x2,
    input  logic [W3-1:0] i_x3,
    output logic          o_valid,
    output logic          o_err,
    output logic [WM-1:0] o_v
);

    localparam int WT1 = crt_weight(M1, M);
    localparam int WT2 = crt_weight(M2, M);
    localparam int WT3 = crt_weight(M3, M);
    localparam int PW1 = WM + W1;
    localparam int PW2 = WM + W2;
    localparam int PW3 = WM + W3;
    localparam logic [WM+1:0] C_M  = (WM+2)'(M);
    localparam logic [WM+1:0] C_2M = (WM+2)'(2 * M);

    logic [PW1-1:0] w_p1;
    logic [PW2-1:0] w_p2;
    logic [PW3-1:0] w_p3;
    logic [WM-1:0]  w_t1;
    logic [WM-1:0]  w_t2;
    logic [WM-1:0]  w_t3;
    logic           w_bad;
    logic [WM+1:0]  w_sum;
    logic [WM+1:0]  w_r1;
    logic [WM+1:0]  w_r2;

    logic          r_v1;
    logic          r_e1;
    logic [WM-1:0] r_t1;
    logic [WM-1:0] r_t2;
    logic [WM-1:0] r_t3;
    logic          r_v2;
    logic          r_e2;
    logic [WM-1:0] r_val;

    assign w_p1 = PW1'(i_x1) * PW1'(WT1);
    assign w_p2 = PW2'(i_x2) * PW2'(WT2);
    assign w_p3 = PW3'(i_x3) * PW3'(WT3);

    // Each term is folded below M so the three-term sum stays under 3M.
    assign w_t1 = WM'(w_p1 % PW1'(M));
    assign w_t2 = WM'(w_p2 % PW2'(M));
    assign w_t3 = WM'(w_p3 % PW3'(M));

    assign w_bad = ({1'b0, i_x1} >= (W1+1)'(M1))
                || ({1'b0, i_x2} >= (W2+1)'(M2))
                || ({1'b0, i_x3} >= (W3+1)'(M3));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_e1 <= 1'b0;
            r_t1 <= '0;
            r_t2 <= '0;
            r_t3 <= '0;
        end else if (i_en) begin
            r_v1 <= i_valid;
            r_e1 <= w_bad;
            r_t1 <= w_t1;
            r_t2 <= w_t2;
            r_t3 <= w_t3;
        end
    end

    assign w_sum = (WM+2)'(r_t1) + (WM+2)'(r_t2) + (WM+2)'(r_t3);
    assign w_r1  = (w_sum >= C_2M) ? (w_sum - C_2M) : w_sum;
    assign w_r2  = (w_r1 >= C_M) ? (w_r1 - C_M) : w_r1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2  <= 1'b0;
            r_e2  <= 1'b0;
            r_val <= '0;
        end else if (i_en) begin
            r_v2  <= r_v1;
            r_e2  <= r_e1;
            r_val <= WM'(w_r2);
        end
    end

    assign o_valid = r_v2;
    assign o_err   = r_e2;
    assign o_v     = r_val;

endmodule

// File: rtl/rns_compare_pipe.sv
// Three-stage RNS-operand vs. programmable-threshold comparator
// with valid/ready handshakes and residue range flagging.
module rns_compare_pipe
    import rns_pkg::*;
#(
    parameter int M1        = RNS_M1,
    parameter int M2        = RNS_M2,
    parameter int M3        = RNS_M3,
    parameter int RST_CONST = 10,
    localparam int W1 = $clog2(M1),
    localparam int W2 = $clog2(M2),
    localparam int W3 = $clog2(M3),
    localparam int M  = M1 * M2 * M3,
    localparam int WM = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W1-1:0] x1,
    input  logic [W2-1:0] x2,
    input  logic [W3-1:0] x3,
    input  logic          cfg_we,
    input  logic [WM-1:0] cfg_const,
    output logic          cfg_err,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          le,
    output logic          eq,
    output logic          gr,
    output logic          err
);

    logic          w_adv;
    logic          w_cfg_ok;
    logic          w_cfg_bad;
    logic [WM-1:0] w_t_acc;
    logic          w_v2;
    logic          w_e2;
    logic [WM-1:0] w_v;

    logic [WM-1:0] r_thr;
    logic          r_cfg_err;
    logic [WM-1:0] r_tq1;
    logic [WM-1:0] r_tq2;
    logic          r_ov;
    logic          r_le;
    logic          r_eq;
    logic          r_gr;
    logic          r_err;

    assign w_adv    = !r_ov || out_ready;
    assign in_ready = w_adv;

    assign w_cfg_ok  = cfg_we && ({1'b0, cfg_const} < (WM+1)'(M));
    assign w_cfg_bad = cfg_we && !w_cfg_ok;

    // A load in the accept cycle already applies to the accepted operand.
    assign w_t_acc = w_cfg_ok ? cfg_const : r_thr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_thr     <= WM'(RST_CONST);
            r_cfg_err <= 1'b0;
        end else begin
            if (w_cfg_ok) begin
                r_thr <= cfg_const;
            end
            r_cfg_err <= w_cfg_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tq1 <= '0;
            r_tq2 <= '0;
        end else if (w_adv) begin
            r_tq1 <= w_t_acc;
            r_tq2 <= r_tq1;
        end
    end

    rns_crt_to_bin #(
        .M1(M1),
        .M2(M2),
        .M3(M3)
    ) u_crt (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_adv),
        .i_valid(in_valid),
        .i_x1   (x1),
        .i_x2   (x2),
        .i_x3   (x3),
        .o_valid(w_v2),
        .o_err  (w_e2),
        .o_v    (w_v)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ov  <= 1'b0;
            r_le  <= 1'b0;
            r_eq  <= 1'b0;
            r_gr  <= 1'b0;
            r_err <= 1'b0;
        end else if (w_adv) begin
            r_ov  <= w_v2;
            r_err <= w_v2 && w_e2;
            r_le  <= w_v2 && !w_e2 && (w_v < r_tq2);
            r_eq  <= w_v2 && !w_e2 && (w_v == r_tq2);
            r_gr  <= w_v2 && !w_e2 && (w_v > r_tq2);
        end
    end

    assign cfg_err   = r_cfg_err;
    assign out_valid = r_ov;
    assign le        = r_le;
    assign eq        = r_eq;
    assign gr        = r_gr;
    assign err       = r_err;

endmodule
